// File: rtl/rv32_hpm_pkg.sv
// Shared constants for the RV32 hardware performance-monitor bank:
// CSR base addresses, the OF bit position and the selector width helper.
package rv32_hpm_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;

    // mhpmevent3..31 / mhpmcounter3..31(h): 29 indices per group
    localparam logic [11:0] CSR_GROUP_SIZE = 12'd29;

    // Sticky overflow flag position inside mhpmevent
    localparam int unsigned OF_BIT = 31;

    typedef enum logic [2:0] {
        HPM_NONE,
        HPM_INHIBIT,
        HPM_EVENT,
        HPM_CNT_LO,
        HPM_CNT_HI
    } hpm_csr_kind_e;

    // Selector width: must encode 0 (never) plus 1..num_events
    function automatic int unsigned hpm_event_width(input int unsigned num_events);
        return $clog2(num_events + 1);
    endfunction

endpackage

// File: rtl/rv32_hpm_counter.sv
// One performance-counter slice: WARL event selector, split-write counter,
// inhibit gating and (with RV32_HPM_OVERFLOW_IRQ_EN) a sticky OF bit.
module rv32_hpm_counter
    import rv32_hpm_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 40,
    parameter int unsigned NUM_EVENTS    = 8,
    parameter int unsigned EW            = hpm_event_width(NUM_EVENTS)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     inhibit_i,
    input  logic [NUM_EVENTS-1:0]    events_i,
    input  logic                     sel_we_i,
    input  logic                     cnt_lo_we_i,
    input  logic                     cnt_hi_we_i,
    input  logic [31:0]              write_value_i,
    output logic [EW-1:0]            sel_o,
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
    output logic                     of_o,
`endif
    output logic [COUNTER_WIDTH-1:0] count_o
);

    logic [EW-1:0]            sel_q, sel_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     ev_hit;
    logic                     inc;
    logic                     wrap;

    // Pick the latched strobe named by the selector (0 never matches)
    always_comb begin
        ev_hit = 1'b0;
        for (int unsigned e = 0; e < NUM_EVENTS; e++) begin
            if (sel_q == EW'(e + 1)) ev_hit = events_i[e];
        end
    end

    assign inc  = ev_hit && !inhibit_i;
    // A write to either half drops the increment, so it cannot wrap either
    assign wrap = inc && !cnt_lo_we_i && !cnt_hi_we_i && (cnt_q == '1);

    // Next-state for selector and counter; software writes beat increments
    always_comb begin
        sel_d = sel_q;
        if (sel_we_i) begin
            sel_d = (write_value_i[30:0] <= 31'(NUM_EVENTS)) ? write_value_i[EW-1:0] : '0;
        end

        cnt_d = cnt_q;
        if (cnt_lo_we_i) begin
            cnt_d[31:0] = write_value_i;
        end else if (cnt_hi_we_i) begin
            cnt_d[COUNTER_WIDTH-1:32] = write_value_i[COUNTER_WIDTH-33:0];
        end else if (inc) begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
    end

    // Selector and counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef RV32_HPM_OVERFLOW_IRQ_EN
    logic of_q, of_d;

    // Sticky OF: software may write it, a wrap in the same cycle still sets it
    always_comb begin
        of_d = of_q;
        if (sel_we_i) of_d = write_value_i[OF_BIT];
        if (wrap)     of_d = 1'b1;
    end

    // OF register
    always_ff @(posedge clk_i) begin
        if (reset_i) of_q <= 1'b0;
        else         of_q <= of_d;
    end

    assign of_o = of_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

    assign sel_o   = sel_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/rv32_hpm_counters.sv
// RV32 hardware performance-monitor bank: decodes mcountinhibit,
// mhpmevent3..31 and mhpmcounter3..31(h), registers the event strobes and
// drives NUM_COUNTERS counter slices. RV32_HPM_OVERFLOW_IRQ_EN adds OF bits
// and the overflow_irq_out port.
module rv32_hpm_counters
    import rv32_hpm_pkg::*;
#(
    parameter int unsigned NUM_COUNTERS  = 4,
    parameter int unsigned COUNTER_WIDTH = 40,
    parameter int unsigned NUM_EVENTS    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic [11:0]           csr_in,
    input  logic                  write_in,
    input  logic [31:0]           write_value_in,
    input  logic [NUM_EVENTS-1:0] event_in,
    output logic                  hit_out,
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
    output logic                  overflow_irq_out,
`endif
    output logic [31:0]           read_value_out
);

    localparam int unsigned EW = hpm_event_width(NUM_EVENTS);

    hpm_csr_kind_e           kind;
    logic [4:0]              idx;
    logic [11:0]             off_evt, off_lo, off_hi;
    logic                    wen;
    logic [NUM_EVENTS-1:0]   ev_q;
    logic [NUM_COUNTERS-1:0] inh_q, inh_d;
    logic [EW-1:0]            sel_w [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_w [NUM_COUNTERS];
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
    logic [NUM_COUNTERS-1:0] of_w;
    logic                    irq_q;
`endif

    assign off_evt = csr_in - CSR_MHPMEVENT3;
    assign off_lo  = csr_in - CSR_MHPMCOUNTER3;
    assign off_hi  = csr_in - CSR_MHPMCOUNTER3H;
    assign wen     = write_in && !stall_in;

    // Classify the address; unimplemented indices still hit and read 0
    always_comb begin
        kind = HPM_NONE;
        idx  = '0;
        if (csr_in == CSR_MCOUNTINHIBIT) begin
            kind = HPM_INHIBIT;
        end else if (off_evt < CSR_GROUP_SIZE) begin
            kind = HPM_EVENT;
            idx  = off_evt[4:0];
        end else if (off_lo < CSR_GROUP_SIZE) begin
            kind = HPM_CNT_LO;
            idx  = off_lo[4:0];
        end else if (off_hi < CSR_GROUP_SIZE) begin
            kind = HPM_CNT_HI;
            idx  = off_hi[4:0];
        end
    end

    assign hit_out = (kind != HPM_NONE);

    // Read mux; defaults to 0 for misses and unimplemented indices
    always_comb begin
        read_value_out = '0;
        case (kind)
            HPM_INHIBIT: read_value_out = 32'(inh_q) << 3;
            HPM_EVENT: begin
                for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                    if (idx == 5'(i)) begin
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
                        read_value_out = 32'(sel_w[i]) | (32'(of_w[i]) << OF_BIT);
`else
                        read_value_out = 32'(sel_w[i]);
`endif
                    end
                end
            end
            HPM_CNT_LO: begin
                for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                    if (idx == 5'(i)) read_value_out = cnt_w[i][31:0];
                end
            end
            HPM_CNT_HI: begin
                for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                    if (idx == 5'(i)) read_value_out = 32'(cnt_w[i][COUNTER_WIDTH-1:32]);
                end
            end
            default: read_value_out = '0;
        endcase
    end

    // mcountinhibit next-state: only bits [3+N-1:3] are stored
    always_comb begin
        inh_d = inh_q;
        if (wen && kind == HPM_INHIBIT) inh_d = write_value_in[3 +: NUM_COUNTERS];
    end

    // Event latch stage and inhibit register
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_q  <= '0;
            inh_q <= '0;
        end else begin
            ev_q  <= event_in;
            inh_q <= inh_d;
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
        rv32_hpm_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .NUM_EVENTS    (NUM_EVENTS),
            .EW            (EW)
        ) u_cnt (
            .clk_i         (clk),
            .reset_i       (reset),
            .inhibit_i     (inh_q[i]),
            .events_i      (ev_q),
            .sel_we_i      (wen && kind == HPM_EVENT  && idx == 5'(i)),
            .cnt_lo_we_i   (wen && kind == HPM_CNT_LO && idx == 5'(i)),
            .cnt_hi_we_i   (wen && kind == HPM_CNT_HI && idx == 5'(i)),
            .write_value_i (write_value_in),
            .sel_o         (sel_w[i]),
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
            .of_o          (of_w[i]),
`endif
            .count_o       (cnt_w[i])
        );
    end

`ifdef RV32_HPM_OVERFLOW_IRQ_EN
    // Interrupt request is the registered OR of all sticky OF bits
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= |of_w;
    end

    assign overflow_irq_out = irq_q;
`endif

endmodule

// File: tb/tb_rv32_hpm_counters.sv
// Directed self-checking bench for rv32_hpm_counters (default parameters:
// 4 counters, 40-bit, 8 events). OF/interrupt checks are compiled in when
// RV32_HPM_OVERFLOW_IRQ_EN is defined.
module tb_rv32_hpm_counters;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_in = 1'b0;
    logic [11:0] csr_in = '0;
    logic        write_in = 1'b0;
    logic [31:0] write_value_in = '0;
    logic [7:0]  event_in = '0;
    logic        hit_out;
    logic [31:0] read_value_out;
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
    logic        overflow_irq_out;
`endif

    int checks = 0;
    int errors = 0;

    rv32_hpm_counters #(
        .NUM_COUNTERS  (4),
        .COUNTER_WIDTH (40),
        .NUM_EVENTS    (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .csr_in           (csr_in),
        .write_in         (write_in),
        .write_value_in   (write_value_in),
        .event_in         (event_in),
        .hit_out          (hit_out),
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
        .overflow_irq_out (overflow_irq_out),
`endif
        .read_value_out   (read_value_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Combinational read, sampled mid-cycle
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_in = a;
        #1;
        chk(tag, read_value_out, exp);
    endtask

    task automatic hit(input string tag, input logic [11:0] a, input logic exp);
        csr_in = a;
        #1;
        chk(tag, {31'b0, hit_out}, {31'b0, exp});
    endtask

    // One-cycle CSR write; returns at the negedge after the write edge
    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        csr_in = a;
        write_value_in = v;
        write_in = 1'b1;
        @(negedge clk);
        write_in = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] ev, input int n);
        event_in = ev;
        repeat (n) @(negedge clk);
        event_in = '0;
    endtask

    initial begin
        // Reset for two cycles
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd("rst_inhibit", 12'h320, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd("rst_event", 12'(12'h323 + i), 32'h0);
            rd("rst_cnt_lo", 12'(12'hB03 + i), 32'h0);
            rd("rst_cnt_hi", 12'(12'hB83 + i), 32'h0);
        end
        hit("hit_b03", 12'hB03, 1'b1);
        hit("hit_300", 12'h300, 1'b0);
        rd("rd_300", 12'h300, 32'h0);
        hit("hit_33f", 12'h33F, 1'b1);
        hit("hit_340", 12'h340, 1'b0);
        hit("hit_b9f", 12'hB9F, 1'b1);
        hit("hit_ba0", 12'hBA0, 1'b0);
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
        chk("rst_irq", {31'b0, overflow_irq_out}, 32'h0);
`endif

        // Counting: five pulses of event 2 (event_in[1]) into counter 3
        wr(12'h323, 32'd2);
        rd("evt3_sel", 12'h323, 32'd2);
        pulse(8'h02, 5);
        rd("cnt3_lag", 12'hB03, 32'd4);
        @(negedge clk);
        rd("cnt3_five", 12'hB03, 32'd5);

        // Two strobes in one cycle feed two counters
        wr(12'h324, 32'd1);
        pulse(8'h03, 1);
        @(negedge clk);
        rd("cnt3_multi", 12'hB03, 32'd6);
        rd("cnt4_multi", 12'hB04, 32'd1);

        // WARL selector
        wr(12'h324, 32'd200);
        rd("warl_200", 12'h324, 32'd0);
        wr(12'h324, 32'd8);
        rd("warl_8", 12'h324, 32'd8);
        wr(12'h324, 32'd9);
        rd("warl_9", 12'h324, 32'd0);
`ifndef RV32_HPM_OVERFLOW_IRQ_EN
        wr(12'h324, 32'h8000_0003);
        rd("evt_bit31", 12'h324, 32'd3);
`endif
        wr(12'h324, 32'd0);

        // Unimplemented index: hits, reads 0, ignores writes
        wr(12'hB1F, 32'd5);
        rd("unimpl_b1f", 12'hB1F, 32'h0);

        // Inhibit
        wr(12'h320, 32'hFFFF_FFFF);
        rd("inhibit_rd", 12'h320, 32'h78);
        pulse(8'h02, 3);
        repeat (2) @(negedge clk);
        rd("cnt3_inhib", 12'hB03, 32'd6);
        wr(12'h320, 32'h0);

        // Write collides with a landing increment
        pulse(8'h02, 1);
        wr(12'hB03, 32'h10);
        rd("collide_lo", 12'hB03, 32'h10);
        pulse(8'h02, 1);
        wr(12'hB83, 32'h0);
        rd("collide_hi", 12'hB03, 32'h10);

        // Stall blocks writes but not counting
        stall_in = 1'b1;
        wr(12'hB03, 32'h55);
        rd("stall_wr", 12'hB03, 32'h10);
        pulse(8'h02, 1);
        @(negedge clk);
        stall_in = 1'b0;
        rd("stall_cnt", 12'hB03, 32'h11);

        // Wrap across halves
        wr(12'hB83, 32'hFFFF_FFFF);
        rd("hi_ff", 12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        rd("lo_ff", 12'hB03, 32'hFFFF_FFFF);
        rd("hi_keep", 12'hB83, 32'hFF);
        pulse(8'h02, 1);
        @(negedge clk);
        rd("wrap_hi", 12'hB83, 32'h0);
        rd("wrap_lo", 12'hB03, 32'h0);
`ifdef RV32_HPM_OVERFLOW_IRQ_EN
        rd("of_set", 12'h323, 32'h8000_0002);
        chk("irq_lag", {31'b0, overflow_irq_out}, 32'h0);
        @(negedge clk);
        chk("irq_set", {31'b0, overflow_irq_out}, 32'h1);
        wr(12'h323, 32'd2);
        rd("of_clr", 12'h323, 32'd2);
        chk("irq_hold", {31'b0, overflow_irq_out}, 32'h1);
        @(negedge clk);
        chk("irq_clr", {31'b0, overflow_irq_out}, 32'h0);
`endif

        // Reset mid-operation clears everything
        wr(12'hB03, 32'd7);
        pulse(8'h02, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd("mid_rst_cnt", 12'hB03, 32'h0);
        rd("mid_rst_evt", 12'h323, 32'h0);
        @(negedge clk);
        rd("mid_rst_cnt2", 12'hB03, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_hpm_counters.md
# rv32_hpm_counters

Parametrised hardware performance-monitor bank for the RV32 core, replacing the hardwired-zero mhpmcounter3..31, mhpmcounter3h..31h and mhpmevent3..31 CSRs with real counters. It decodes its own CSR addresses and sits beside the main CSR file in the execute stage. The main CSR file muxes this block's read value when `hit_out` is high and forwards the resolved write value. Per-cycle event strobes come from the pipeline.

## Interface
- `NUM_COUNTERS`, default 4: implemented counters mhpmcounter3..(3+NUM_COUNTERS-1); legal range 1..29.
- `COUNTER_WIDTH`, default 40: counter width in bits; legal range 33..64.
- `NUM_EVENTS`, default 8: number of event strobes; legal range 1..255.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high reset.
- `stall_in` in 1: pipeline stall; blocks CSR writes only.
- `csr_in` in 12: CSR address.
- `write_in` in 1: CSR write request.
- `write_value_in` in 32: final value to store (RW/RS/RC already resolved by the CSR file).
- `event_in` in NUM_EVENTS: one-cycle event strobes; several bits may be high in the same cycle.
- `hit_out` out 1: `csr_in` addresses a CSR owned by this block (combinational).
- `read_value_out` out 32: read data for `csr_in` (combinational); 0 when `hit_out` is low.
- `overflow_irq_out` out 1: overflow interrupt request. Exists only with the macro; see Configuration.

## Operation
- Owned CSRs:
  - mcountinhibit 0x320: bits [3+N-1:3] are writable; all other bits read 0.
  - mhpmevent3+i at 0x323+i.
  - mhpmcounter3+i at 0xB03+i.
  - mhpmcounter3+ih at 0xB83+i, for i < NUM_COUNTERS.
  - Unimplemented indices up to 31 also give `hit_out`=1 and read 0; writes to them are ignored.
- mhpmevent selector is WARL, width EW = $clog2(NUM_EVENTS+1).
  - Value 0 means never count.
  - Value v in 1..NUM_EVENTS counts `event_in[v-1]`.
  - Writing any value > NUM_EVENTS stores 0. Read returns the stored selector, zero-extended.
- Event path is registered. Stage 1 latches `event_in`. Stage 2 increments counter i by 1 when the latched selected bit is 1 and inhibit bit i is 0.
- Counter i wraps from 2^COUNTER_WIDTH-1 to 0.
- Low CSR reads counter[31:0]. High CSR reads counter[W-1:32], zero-extended to 32 bits.
- Writes take effect when `write_in && !stall_in`:
  - A low write replaces bits [31:0].
  - A high write replaces bits [W-1:32] with `write_value_in[W-33:0]`.
  - The untouched half keeps its value.
- Write vs. increment in the same cycle on the same counter: the write wins and that increment is dropped. A write to the other half also drops the increment.
- An inhibit write takes effect for increments applied from the next cycle onward.
- Reset values:
  - All counters, selectors and mcountinhibit are 0.
  - The event pipeline register is cleared.
  - `overflow_irq_out` is 0.
  - `read_value_out` follows the cleared registers.

## Timing
- Reads are combinational, with zero latency.
- A write is visible on a read in the next cycle.
- An event strobe in cycle t becomes visible in the counter in cycle t+2.
- Reset asserted mid-operation clears all state on that edge, including any in-flight latched events. The cycle after reset deasserts observes all zeros.
- `stall_in` does not freeze counting.

## Configuration
- `RV32_HPM_OVERFLOW_IRQ_EN` defined:
  - Each mhpmevent gains a sticky OF bit [31].
  - OF is set when its counter wraps, and can be written by software (writing 0 clears it).
  - `overflow_irq_out` is the registered OR of all OF bits. It rises the cycle after the wrap edge.
  - If a write to OF and a wrap happen in the same cycle, the wrap wins.
- `RV32_HPM_OVERFLOW_IRQ_EN` undefined:
  - mhpmevent[31] reads 0 and ignores writes.
  - The `overflow_irq_out` port and the OF logic are absent.

## Structure
- Package `rv32_hpm_pkg` holds:
  - CSR base addresses (0x320, 0x323, 0xB03, 0xB83);
  - the OF bit position;
  - the helper function computing EW.
- Sub-module `rv32_hpm_counter` implements one counter slice: selector, counter, inhibit input, write ports, OF bit. The bank instantiates it NUM_COUNTERS times in a generate loop.

## Test plan
- Reset: assert `reset` for 2 cycles. Every owned CSR then reads 0 and `hit_out`=1 for 0xB03. Address 0x300 gives `hit_out`=0 and read 0.
- Counting: write mhpmevent3=2, then pulse `event_in[1]` for 5 cycles. mhpmcounter3 reads 5, two cycles after the last pulse.
- WARL and inhibit:
  - Write mhpmevent4=200 with NUM_EVENTS=8; it reads back 0.
  - Set mcountinhibit bit 3 and pulse the selected event 3 times; mhpmcounter3 stays unchanged.
- Collision and stall:
  - Write mhpmcounter3=0x10 in the same cycle its increment lands; it reads 0x10.
  - A write with `stall_in`=1 has no effect.
- Wrap across halves:
  - Write the high half = 0xFF and the low half = 0xFFFFFFFF (W=40), then send one event. High reads 0 and low reads 0.
  - With the macro, OF=1 and `overflow_irq_out`=1 one cycle later.
  - Writing mhpmevent3[31]=0 clears OF.
